// File: rtl/reaction_delay_timer.sv
// reaction_delay_timer
// Turns a free-running 13-bit random value into a stimulus delay for the
// reaction-time game. It counts the delay down in milliseconds, lights the
// stimulus LED, and then measures how many milliseconds pass before the
// player presses the button. It reports the reaction time, false starts
// (a press before the LED) and timeouts (no press within MAX_MS).
//
// Every output is a register that is loaded from the next-state view of
// the FSM, so the outputs change on the same edge as the state.

module reaction_delay_timer #(
  parameter int unsigned TICKS_PER_MS = 100000,
  parameter int unsigned MAX_MS       = 9999
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Button,
  input  logic [12:0] RandomValue,
  output logic        Led,
  output logic        Busy,
  output logic        Valid,
  output logic [13:0] ReactionMs,
  output logic        EarlyFlag,
  output logic        TimeoutFlag
);

  // Prescaler width; at least one bit even for tiny tick periods.
  localparam int unsigned PRESC_W = (TICKS_PER_MS > 32'd1) ? $clog2(TICKS_PER_MS) : 32'd1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_MS - 32'd1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(32'd1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO = PRESC_W'(32'd0);

  // Reaction-time saturation value and the value one tick before it.
  localparam logic [13:0] REACT_MAX = 14'(MAX_MS);
  localparam logic [13:0] REACT_PRE = 14'(MAX_MS - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_MEAS = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // A random value of zero would give no delay at all; the shortest delay
  // the game allows is one millisecond.
  function automatic logic [12:0] delay_from_random(input logic [12:0] value);
    logic [12:0] result;
    if (value == 13'd0) begin
      result = 13'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

  // Saturating millisecond increment for the reaction counter.
  function automatic logic [13:0] react_increment(input logic [13:0] value);
    logic [13:0] result;
    if (value >= REACT_PRE) begin
      result = REACT_MAX;
    end else begin
      result = value + 14'd1;
    end
    return result;
  endfunction

  // FSM state
  state_t r_state;
  state_t w_state_nxt;

  // Button edge detection
  logic r_button_q;
  logic w_press_edge;

  // Millisecond prescaler
  logic [PRESC_W-1:0] r_presc;
  logic               w_ms_tick;

  // A Start that is honoured (only from IDLE or DONE)
  logic w_start_round;

  // Datapath registers and their next values
  logic [12:0] r_delay;
  logic [12:0] w_delay_nxt;
  logic [13:0] r_react;
  logic [13:0] w_react_nxt;
  logic        r_early;
  logic        w_early_nxt;
  logic        r_timeout;
  logic        w_timeout_nxt;

  // Registered status outputs and their next values
  logic r_led;
  logic r_busy;
  logic r_valid;
  logic w_led_nxt;
  logic w_busy_nxt;
  logic w_valid_nxt;

  assign w_press_edge  = Button & ~r_button_q;
  assign w_ms_tick     = (r_presc == PRESC_LAST);
  assign w_start_round = Start & ((r_state == S_IDLE) | (r_state == S_DONE));

  assign Led         = r_led;
  assign Busy        = r_busy;
  assign Valid       = r_valid;
  assign ReactionMs  = r_react;
  assign EarlyFlag   = r_early;
  assign TimeoutFlag = r_timeout;

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Previous button level; reset to pressed so a button held through reset never looks like a new press.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_button_q <= 1'b1;
    end else begin
      r_button_q <= Button;
    end
  end

  // Millisecond prescaler: restarts on every state entry and only runs while timing.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_presc <= PRESC_ZERO;
    end else if (w_state_nxt != r_state) begin
      r_presc <= PRESC_ZERO;
    end else if ((r_state != S_WAIT) && (r_state != S_MEAS)) begin
      r_presc <= PRESC_ZERO;
    end else if (w_ms_tick) begin
      r_presc <= PRESC_ZERO;
    end else begin
      r_presc <= r_presc + PRESC_ONE;
    end
  end

  // Next-state logic; a press beats an expiring tick, so a press on the last delay tick is a false start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (w_press_edge) begin
          w_state_nxt = S_DONE;
        end else if (w_ms_tick && (r_delay == 13'd1)) begin
          w_state_nxt = S_MEAS;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_MEAS: begin
        if (w_press_edge) begin
          w_state_nxt = S_DONE;
        end else if (w_ms_tick && (r_react >= REACT_PRE)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_MEAS;
        end
      end
      S_DONE: begin
        if (Start) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output/datapath next values: delay latch and countdown, reaction count, result flags.
  always_comb begin
    w_delay_nxt   = r_delay;
    w_react_nxt   = r_react;
    w_early_nxt   = r_early;
    w_timeout_nxt = r_timeout;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_round) begin
          w_delay_nxt   = delay_from_random(RandomValue);
          w_react_nxt   = 14'd0;
          w_early_nxt   = 1'b0;
          w_timeout_nxt = 1'b0;
        end else begin
          w_delay_nxt   = r_delay;
        end
      end
      S_WAIT: begin
        if (w_press_edge) begin
          w_early_nxt = 1'b1;
          w_react_nxt = 14'd0;
        end else if (w_ms_tick) begin
          w_delay_nxt = r_delay - 13'd1;
        end else begin
          w_delay_nxt = r_delay;
        end
      end
      S_MEAS: begin
        if (w_press_edge) begin
          // The press wins over a coincident tick: that tick is not counted.
          w_react_nxt = r_react;
        end else if (w_ms_tick) begin
          w_react_nxt = react_increment(r_react);
          if (r_react >= REACT_PRE) begin
            w_timeout_nxt = 1'b1;
          end else begin
            w_timeout_nxt = 1'b0;
          end
        end else begin
          w_react_nxt = r_react;
        end
      end
      default: begin
        w_delay_nxt = r_delay;
      end
    endcase
  end

  // Status outputs derived from the state being entered, so they are registered alongside it.
  always_comb begin
    w_led_nxt   = 1'b0;
    w_busy_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_led_nxt   = 1'b0;
      end
      S_WAIT: begin
        w_busy_nxt  = 1'b1;
      end
      S_MEAS: begin
        w_led_nxt   = 1'b1;
        w_busy_nxt  = 1'b1;
      end
      S_DONE: begin
        w_valid_nxt = 1'b1;
      end
      default: begin
        w_led_nxt   = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset discards any round in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_delay   <= 13'd0;
      r_react   <= 14'd0;
      r_early   <= 1'b0;
      r_timeout <= 1'b0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_delay   <= w_delay_nxt;
      r_react   <= w_react_nxt;
      r_early   <= w_early_nxt;
      r_timeout <= w_timeout_nxt;
      r_led     <= w_led_nxt;
      r_busy    <= w_busy_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

endmodule
